// File: rtl/dsp48a1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp48a1_pkg
// Description : Shared constants for the DSP48A1 slice model: datapath widths,
//               OPMODE field positions, X/Z operand select encodings and the
//               carry-in source names.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp48a1_pkg;

    // Datapath widths
    localparam int c_p_width  = 48;
    localparam int c_m_width  = 36;
    localparam int c_ab_width = 18;
    localparam int c_d_used   = 12;   // only D[11:0] reaches the X mux

    // OPMODE field positions
    localparam int c_op_x_lsb = 0;
    localparam int c_op_z_lsb = 2;
    localparam int c_op_cin   = 5;
    localparam int c_op_sub   = 7;

    // X select encodings (OPMODE[1:0])
    localparam logic [1:0] c_x_zero = 2'b00;
    localparam logic [1:0] c_x_m    = 2'b01;
    localparam logic [1:0] c_x_p    = 2'b10;
    localparam logic [1:0] c_x_dab  = 2'b11;

    // Z select encodings (OPMODE[3:2])
    localparam logic [1:0] c_z_zero = 2'b00;
    localparam logic [1:0] c_z_pcin = 2'b01;
    localparam logic [1:0] c_z_p    = 2'b10;
    localparam logic [1:0] c_z_c    = 2'b11;

    // Carry-in source names
    localparam string c_cin_opmode5 = "OPMODE5";
    localparam string c_cin_port    = "CARRYIN";

endpackage : dsp48a1_pkg
`default_nettype wire

// File: rtl/reg_mux.sv
`default_nettype none
// ============================================================================
// Module      : reg_mux
// Description : Optional pipeline register. With REG != 0 the input is
//               captured on the rising clock edge when i_ce is high and
//               cleared by the synchronous reset (reset beats enable). With
//               REG == 0 the input passes straight through.
// Ports       : i_clk  - clock
//               i_rst  - synchronous active-high reset
//               i_ce   - clock enable
//               i_d    - data in  [WIDTH-1:0]
//               o_q    - data out [WIDTH-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module reg_mux #(
    parameter int WIDTH = 1,
    parameter int REG   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (REG != 0) begin : g_reg
            logic [WIDTH-1:0] r_q;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_q <= '0;
                end else if (i_ce) begin
                    r_q <= i_d;
                end
            end

            assign o_q = r_q;
        end else begin : g_bypass
            // Clock, reset and enable have no effect in bypass mode.
            logic w_unused;
            assign w_unused = &{1'b0, i_clk, i_rst, i_ce};
            assign o_q      = i_d;
        end
    endgenerate

endmodule : reg_mux
`default_nettype wire

// File: rtl/post_adder_stage.sv
`default_nettype none
// ============================================================================
// Module      : post_adder_stage
// Description : Final arithmetic stage of the DSP48A1 slice. Selects the X
//               and Z operands from OPMODE, selects and optionally registers
//               the carry-in, adds or subtracts, and drives P / CARRYOUT
//               through optional output registers. P feeds back into X/Z for
//               accumulation.
// Ports       : CLK        - clock, rising edge
//               RSTP       - sync active-high reset for P, CARRYOUT and CYI
//               CEP        - enable for P and CARRYOUT registers
//               CECARRYIN  - enable for the CYI register
//               OPMODE[7:0]- [1:0] X sel, [3:2] Z sel, [5] carry, [7] subtract
//               M[35:0]    - signed multiplier product
//               D/A/B[17:0]- operands for the {D[11:0],A,B} concatenation
//               C[47:0]    - C operand
//               PCIN[47:0] - cascade input
//               CARRYIN    - external carry-in
//               P[47:0], PCOUT[47:0], CARRYOUT, CARRYOUTF - results
// Revision    : 1.0 - initial release
// ============================================================================
module post_adder_stage
    import dsp48a1_pkg::*;
#(
    parameter int    PREG        = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    CARRYINREG  = 1,
    parameter string CARRYINSEL  = "OPMODE5"
) (
    input  logic                  CLK,
    input  logic                  RSTP,
    input  logic                  CEP,
    input  logic                  CECARRYIN,
    input  logic [7:0]            OPMODE,
    input  logic [c_m_width-1:0]  M,
    input  logic [c_ab_width-1:0] D,
    input  logic [c_ab_width-1:0] A,
    input  logic [c_ab_width-1:0] B,
    input  logic [c_p_width-1:0]  C,
    input  logic [c_p_width-1:0]  PCIN,
    input  logic                  CARRYIN,
    output logic [c_p_width-1:0]  P,
    output logic [c_p_width-1:0]  PCOUT,
    output logic                  CARRYOUT,
    output logic                  CARRYOUTF
);

    logic [c_p_width-1:0] w_x;
    logic [c_p_width-1:0] w_z;
    logic                 w_cin_sel;
    logic                 w_cin;
    logic [c_p_width:0]   w_sum;
    logic [c_p_width-1:0] w_p;
    logic                 w_co;

    // Upper D bits and OPMODE[6]/[4] do not participate in this stage.
    logic w_unused;
    assign w_unused = &{1'b0, D[c_ab_width-1:c_d_used], OPMODE[6], OPMODE[4]};

    // X operand
    always_comb begin
        w_x = '0;
        case (OPMODE[c_op_x_lsb +: 2])
            c_x_zero: w_x = '0;
            c_x_m:    w_x = {{(c_p_width-c_m_width){M[c_m_width-1]}}, M};
            c_x_p:    w_x = w_p;
            c_x_dab:  w_x = {D[c_d_used-1:0], A, B};
            default:  w_x = '0;
        endcase
    end

    // Z operand
    always_comb begin
        w_z = '0;
        case (OPMODE[c_op_z_lsb +: 2])
            c_z_zero: w_z = '0;
            c_z_pcin: w_z = PCIN;
            c_z_p:    w_z = w_p;
            c_z_c:    w_z = C;
            default:  w_z = '0;
        endcase
    end

    // Carry-in source; an unrecognised source name ties carry-in low.
    always_comb begin
        w_cin_sel = 1'b0;
        if (CARRYINSEL == c_cin_opmode5) begin
            w_cin_sel = OPMODE[c_op_cin];
        end else if (CARRYINSEL == c_cin_port) begin
            w_cin_sel = CARRYIN;
        end
    end

    reg_mux #(
        .WIDTH (1),
        .REG   (CARRYINREG)
    ) u_cyi (
        .i_clk (CLK),
        .i_rst (RSTP),
        .i_ce  (CECARRYIN),
        .i_d   (w_cin_sel),
        .o_q   (w_cin)
    );

    // 49-bit arithmetic: bit 48 is the carry on add and the borrow on
    // subtract. Carry-in is folded into X before subtraction.
    always_comb begin
        w_sum = '0;
        if (OPMODE[c_op_sub]) begin
            w_sum = {1'b0, w_z} - ({1'b0, w_x} + {{c_p_width{1'b0}}, w_cin});
        end else begin
            w_sum = {1'b0, w_z} + {1'b0, w_x} + {{c_p_width{1'b0}}, w_cin};
        end
    end

    reg_mux #(
        .WIDTH (c_p_width),
        .REG   (PREG)
    ) u_preg (
        .i_clk (CLK),
        .i_rst (RSTP),
        .i_ce  (CEP),
        .i_d   (w_sum[c_p_width-1:0]),
        .o_q   (w_p)
    );

    reg_mux #(
        .WIDTH (1),
        .REG   (CARRYOUTREG)
    ) u_coreg (
        .i_clk (CLK),
        .i_rst (RSTP),
        .i_ce  (CEP),
        .i_d   (w_sum[c_p_width]),
        .o_q   (w_co)
    );

    assign P         = w_p;
    assign PCOUT     = w_p;
    assign CARRYOUT  = w_co;
    assign CARRYOUTF = w_co;

endmodule : post_adder_stage
`default_nettype wire

// File: tb/tb_post_adder_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_post_adder_stage
// Description : Directed self-checking bench for post_adder_stage. Instance
//               dut uses the default configuration (carry from OPMODE[5]);
//               instance dut_ci takes its carry-in from the CARRYIN port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_post_adder_stage;

    logic        clk;
    logic        rstp;
    logic        cep;
    logic        cecarryin;
    logic [7:0]  opmode;
    logic [35:0] m;
    logic [17:0] d;
    logic [17:0] a;
    logic [17:0] b;
    logic [47:0] c;
    logic [47:0] pcin;
    logic        carryin;

    logic [47:0] p;
    logic [47:0] pcout;
    logic        carryout;
    logic        carryoutf;

    logic [47:0] p_ci;
    logic [47:0] pcout_ci;
    logic        carryout_ci;
    logic        carryoutf_ci;

    int n_checks = 0;
    int n_fail   = 0;

    post_adder_stage dut (
        .CLK       (clk),
        .RSTP      (rstp),
        .CEP       (cep),
        .CECARRYIN (cecarryin),
        .OPMODE    (opmode),
        .M         (m),
        .D         (d),
        .A         (a),
        .B         (b),
        .C         (c),
        .PCIN      (pcin),
        .CARRYIN   (carryin),
        .P         (p),
        .PCOUT     (pcout),
        .CARRYOUT  (carryout),
        .CARRYOUTF (carryoutf)
    );

    post_adder_stage #(
        .PREG        (1),
        .CARRYOUTREG (1),
        .CARRYINREG  (1),
        .CARRYINSEL  ("CARRYIN")
    ) dut_ci (
        .CLK       (clk),
        .RSTP      (rstp),
        .CEP       (cep),
        .CECARRYIN (cecarryin),
        .OPMODE    (opmode),
        .M         (m),
        .D         (d),
        .A         (a),
        .B         (b),
        .C         (c),
        .PCIN      (pcin),
        .CARRYIN   (carryin),
        .P         (p_ci),
        .PCOUT     (pcout_ci),
        .CARRYOUT  (carryout_ci),
        .CARRYOUTF (carryoutf_ci)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstp = 1'b1; cep = 1'b1; cecarryin = 1'b1;
        opmode = 8'b0000_1101; m = 36'd100; c = 48'd23;
        tick();
        tick();
        n_checks++;
        if (p !== 48'd0) begin
            n_fail++; $display("FAIL reset_p: got %h expected %h", p, 48'd0);
        end
        n_checks++;
        if (pcout !== 48'd0) begin
            n_fail++; $display("FAIL reset_pcout: got %h expected %h", pcout, 48'd0);
        end
        n_checks++;
        if (carryout !== 1'b0 || carryoutf !== 1'b0) begin
            n_fail++; $display("FAIL reset_co: got %b/%b expected 0/0", carryout, carryoutf);
        end
        cep = 1'b0;
        tick();
        n_checks++;
        if (p !== 48'd0 || carryout !== 1'b0) begin
            n_fail++; $display("FAIL reset_ce0: got p=%h co=%b expected p=0 co=0", p, carryout);
        end
    endtask

    task automatic test_add();
        rstp = 1'b0; cep = 1'b1; cecarryin = 1'b1;
        opmode = 8'b0000_1101; m = 36'd100; c = 48'd23;
        tick();
        n_checks++;
        if (p !== 48'd123 || carryout !== 1'b0) begin
            n_fail++; $display("FAIL add: got p=%0d co=%b expected p=123 co=0", p, carryout);
        end
        n_checks++;
        if (pcout !== 48'd123) begin
            n_fail++; $display("FAIL add_pcout: got %0d expected 123", pcout);
        end
        // Negative M is sign-extended: -1 + 23 = 22
        m = 36'hF_FFFF_FFFF;
        tick();
        n_checks++;
        if (p !== 48'd22 || carryout !== 1'b1) begin
            n_fail++; $display("FAIL add_neg_m: got p=%0d co=%b expected p=22 co=1", p, carryout);
        end
    endtask

    task automatic test_carry_wrap();
        opmode = 8'b0010_0011;   // X = {D,A,B}, Z = 0, carry = OPMODE[5] = 1
        d = 18'h00FFF; a = 18'h3FFFF; b = 18'h3FFFF;
        // CYI still holds 0 on this edge; it captures 1 at the same time.
        tick();
        n_checks++;
        if (p !== 48'hFFFF_FFFF_FFFF || carryout !== 1'b0) begin
            n_fail++; $display("FAIL wrap_cin_latency: got p=%h co=%b expected p=ffffffffffff co=0", p, carryout);
        end
        tick();
        n_checks++;
        if (p !== 48'd0 || carryout !== 1'b1) begin
            n_fail++; $display("FAIL wrap: got p=%h co=%b expected p=0 co=1", p, carryout);
        end
        n_checks++;
        if (carryoutf !== 1'b1) begin
            n_fail++; $display("FAIL wrap_cof: got %b expected 1", carryoutf);
        end
    endtask

    task automatic test_subtract();
        opmode = 8'b1000_1101;   // subtract, X = M, Z = C, carry source 0
        c = 48'd5; m = 36'd7;
        // CYI is still 1 from the previous test on this edge: 5 - (7 + 1)
        tick();
        n_checks++;
        if (p !== 48'hFFFF_FFFF_FFFD || carryout !== 1'b1) begin
            n_fail++; $display("FAIL sub_stale_cin: got p=%h co=%b expected p=fffffffffffd co=1", p, carryout);
        end
        tick();
        n_checks++;
        if (p !== 48'hFFFF_FFFF_FFFE || carryout !== 1'b1) begin
            n_fail++; $display("FAIL sub_borrow: got p=%h co=%b expected p=fffffffffffe co=1", p, carryout);
        end
        c = 48'd7; m = 36'd5;
        tick();
        n_checks++;
        if (p !== 48'd2 || carryout !== 1'b0) begin
            n_fail++; $display("FAIL sub_noborrow: got p=%h co=%b expected p=2 co=0", p, carryout);
        end
    endtask

    task automatic test_accumulate();
        logic [47:0] exp_seq [4];
        exp_seq[0] = 48'd3; exp_seq[1] = 48'd6; exp_seq[2] = 48'd9; exp_seq[3] = 48'd12;
        opmode = 8'b0000_1001;   // X = M, Z = P
        m = 36'd3;
        rstp = 1'b1; cep = 1'b1;
        tick();
        rstp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (p !== exp_seq[i]) begin
                n_fail++; $display("FAIL accum_step%0d: got %0d expected %0d", i, p, exp_seq[i]);
            end
        end
        // Freeze while operands change
        cep = 1'b0; m = 36'd50;
        tick();
        tick();
        n_checks++;
        if (p !== 48'd12 || carryout !== 1'b0) begin
            n_fail++; $display("FAIL accum_hold: got p=%0d co=%b expected p=12 co=0", p, carryout);
        end
        // Reset overrides a disabled enable
        rstp = 1'b1;
        tick();
        n_checks++;
        if (p !== 48'd0) begin
            n_fail++; $display("FAIL accum_reset: got %0d expected 0", p);
        end
        rstp = 1'b0; cep = 1'b1; m = 36'd3;
        tick();
        n_checks++;
        if (p !== 48'd3) begin
            n_fail++; $display("FAIL accum_restart: got %0d expected 3", p);
        end
    endtask

    task automatic test_carryin_pipeline();
        logic [47:0] exp_a [4];
        exp_a[0] = 48'd0; exp_a[1] = 48'd1; exp_a[2] = 48'd0; exp_a[3] = 48'd0;
        opmode = 8'b0000_0000;   // X = Z = 0
        cep = 1'b1; cecarryin = 1'b1; carryin = 1'b0;
        rstp = 1'b1;
        tick();
        rstp = 1'b0;
        tick();
        carryin = 1'b1;
        tick();
        carryin = 1'b0;
        n_checks++;
        if (p_ci !== 48'd0) begin
            n_fail++; $display("FAIL cin_pulse_edge1: got %0d expected 0", p_ci);
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            n_checks++;
            if (p_ci !== exp_a[i]) begin
                n_fail++; $display("FAIL cin_pulse_edge%0d: got %0d expected %0d", i + 1, p_ci, exp_a[i]);
            end
        end
        // Same pulse with the CYI register disabled
        cecarryin = 1'b0;
        carryin = 1'b1;
        tick();
        carryin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (p_ci !== 48'd0) begin
                n_fail++; $display("FAIL cin_ce0_edge%0d: got %0d expected 0", i + 2, p_ci);
            end
        end
    endtask

    initial begin
        rstp = 1'b1; cep = 1'b0; cecarryin = 1'b0; opmode = 8'd0;
        m = '0; d = '0; a = '0; b = '0; c = '0; pcin = '0; carryin = 1'b0;
        #2;
        test_reset();
        test_add();
        test_carry_wrap();
        test_subtract();
        test_accumulate();
        test_carryin_pipeline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_post_adder_stage
`default_nettype wire

// File: doc/post_adder_stage.md
Name: post_adder_stage

Overview:
- Final arithmetic stage of the DSP48A1 slice model.
- Consumes the multiplier result M, the D:A:B concatenation, the C input and the PCIN cascade.
- Selects X and Z operands per OPMODE, selects and optionally registers carry-in, then adds or subtracts.
- Drives P, PCOUT, CARRYOUT and CARRYOUTF through optional pipeline registers. P feeds back into the X/Z selection for accumulation.

Parameters:
- PREG, 1, 1 = P/PCOUT registered; 0 = combinational.
- CARRYOUTREG, 1, 1 = CARRYOUT/CARRYOUTF registered; 0 = combinational.
- CARRYINREG, 1, 1 = selected carry-in registered (CYI); 0 = combinational.
- CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" = OPMODE[5], "CARRYIN" = CARRYIN port. Any other value forces carry-in to 0.

Ports:
- CLK  in  1  single clock, rising edge.
- RSTP  in  1  synchronous active-high reset for P, CARRYOUT and CYI registers.
- CEP  in  1  clock enable for P and CARRYOUT registers.
- CECARRYIN  in  1  clock enable for CYI register.
- OPMODE  in  8  bits [1:0] X select, [3:2] Z select, [5] carry source, [7] subtract.
- M  in  36  multiplier product (signed).
- D  in  18  pre-adder D operand; bits [11:0] used.
- A  in  18  A operand.
- B  in  18  B operand.
- C  in  48  C operand.
- PCIN  in  48  cascade input.
- CARRYIN  in  1  external carry-in.
- P  out  48  result.
- PCOUT  out  48  copy of P.
- CARRYOUT  out  1  carry/borrow out.
- CARRYOUTF  out  1  copy of CARRYOUT.

Behaviour:
- Reset and clocking: single clock CLK; RSTP is synchronous and active-high. RSTP has priority over all clock enables.
- Reset values: P = 0, PCOUT = 0, CARRYOUT = 0, CARRYOUTF = 0, CYI = 0.
- X mux (OPMODE[1:0]):
  - 00 → 0
  - 01 → M sign-extended to 48 bits
  - 10 → P (the current output value)
  - 11 → {D[11:0], A, B}
- Z mux (OPMODE[3:2]):
  - 00 → 0
  - 01 → PCIN
  - 10 → P
  - 11 → C
- Carry-in: CIN_sel is taken from the source given by CARRYINSEL.
  - CARRYINREG=1: CYI loads CIN_sel on a CLK edge when CECARRYIN=1, else holds.
  - CARRYINREG=0: CIN_sel is used directly.
- Arithmetic uses 49-bit zero-extended operands:
  - OPMODE[7]=0: SUM = Z + X + CIN.
  - OPMODE[7]=1: SUM = Z - (X + CIN).
  - Result = SUM[47:0]; CO = SUM[48] (carry on add, borrow on subtract). All wrap modulo 2^49, with no saturation.
- PREG=1: P loads the result on a CLK edge when CEP=1, else holds. PREG=0: P = result combinationally.
  - Selecting P in X or Z with PREG=0 forms a combinational loop; this configuration is illegal and the bench must not exercise it.
- CARRYOUTREG: identical rule to PREG applied to CO, using CEP.
- Latency, OPMODE/operand change to P: (CARRYINREG? irrelevant) PREG cycles. Carry-in change to P: CARRYINREG + PREG cycles.
- Boundaries:
  - Reset asserted mid-accumulation clears P on that edge; the next accumulate starts from 0.
  - CEP=0 freezes P and CARRYOUT even while operands change.
  - RSTP=1 with CEP=1 → reset wins.
  - OPMODE changes take effect on the same edge, with no pipelining of OPMODE in this block.

Decomposition:
- Shared package dsp48a1_pkg holds OPMODE field positions, X/Z select encodings, the carry-source string constants and width constants (48/36/18).
- One natural sub-module: reg_mux (parameterised width, CE, synchronous reset, register-or-bypass select). It is instantiated for CYI, P and CARRYOUT.

Test Plan:
- Reset: RSTP=1 for 2 cycles with CEP=1 and nonzero operands → P=0, CARRYOUT=0, PCOUT=0. Hold RSTP=1 with CEP=0 → outputs still 0.
- Add: OPMODE=8'b0000_1101 (X=M, Z=C), M=36'd100, C=48'd23, CARRYINSEL="OPMODE5" with OPMODE[5]=0 → P=123 one cycle after the edge, CARRYOUT=0.
- Carry/wrap: X={D,A,B} all ones (48'hFFFF_FFFF_FFFF), Z=0, OPMODE[5]=1, add → P=0, CARRYOUT=1.
- Subtract with borrow: OPMODE[7]=1, Z=C=5, X=M=7, CIN=0 → P=48'hFFFF_FFFF_FFFE, CARRYOUT=1. Then C=7, M=5 → P=2, CARRYOUT=0.
- Accumulate: Z=P, X=M=3, CEP=1 for 4 cycles from reset → P sequence 3, 6, 9, 12. Then CEP=0 for 2 cycles → P holds 12. Then RSTP pulse → P=0.
- Carry-in pipeline: CARRYINSEL="CARRYIN", CARRYINREG=1, CECARRYIN=1, X=Z=0. CARRYIN pulsed high for one cycle → P=1 exactly 2 cycles after the pulse, then back to 0. Same pulse with CECARRYIN=0 → P stays 0.
